product_display: RTL and testbench

Downstream display stage for the 3x3 unsigned multiplier: takes its 6-bit product, converts it sequentially (shift-add-3) to two BCD digits and drives a multiplexed, active-low seven-segment display with leading-zero blanking. Re-conversion is triggered automatically whenever the product changes, so the display tracks the switches continuously. Sits between the multiplier output and the board's segment/anode pins.

---
 rtl/product_display_pkg.sv | 55 +++++
 rtl/product_display_bin2bcd_seq.sv | 70 +++++++
 rtl/product_display.sv | 86 ++++++++
 tb/tb_product_display.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/product_display_pkg.sv
// product_display_pkg
//   Shared definitions for the product display: conversion FSM states,
//   seven-segment patterns (abcdefg order, 0 = lit), anode codes and
//   helpers that map a digit onto the physical segment pins.
package product_display_pkg;

  localparam int DATA_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } conv_state_t;

  // Patterns are written a..g from MSB to LSB.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Pin 0 is segment a, so the abcdefg pattern is bit-reversed onto the pins.
  function automatic logic [6:0] to_seg_pins(input logic [6:0] abcdefg);
    logic [6:0] pins;
    for (int i = 0; i < 7; i++) pins[i] = abcdefg[6-i];
    return pins;
  endfunction

endpackage

// File: rtl/product_display_bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential 6-bit binary to two-digit BCD converter (shift-add-3).
//   Ports:
//     clk, rst_n  clock, synchronous active-low reset
//     start       begin converting bin (honoured only when idle)
//     bin         binary operand 0..63
//     busy        high from the start edge until the done cycle ends
//     done        one-cycle strobe; tens/ones are valid while it is high
//     tens, ones  BCD result digits
module bin2bcd_seq
  import product_display_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [3:0]        tens,
  output logic [3:0]        ones
);

  localparam logic [2:0] SHIFT_LAST = 3'(DATA_W - 1);

  conv_state_t       state, state_next;
  logic [7:0]        bcd;
  logic [7:0]        bcd_adj;
  logic [DATA_W-1:0] operand;
  logic [2:0]        count;

  // Add-3 correction on each nibble before it is doubled by the shift.
  always_comb begin
    bcd_adj = bcd;
    if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (count == SHIFT_LAST) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Datapath carries no reset; it is reloaded on every start.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      operand <= bin;
      bcd     <= '0;
      count   <= '0;
    end else if (state == ST_SHIFT) begin
      {bcd, operand} <= {bcd_adj, operand} << 1;
      count          <= count + 3'd1;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign tens = bcd[7:4];
  assign ones = bcd[3:0];

endmodule

// File: rtl/product_display.sv
// product_display
//   Converts the multiplier product to decimal and drives a two-digit,
//   multiplexed, active-low seven-segment display with a blanked
//   leading zero. A new conversion starts whenever the product differs
//   from the last converted value.
//   Ports:
//     clk, rst_n  clock, synchronous active-low reset
//     product     unsigned product 0..63
//     seg         segment cathodes, active-low, seg[0]=a .. seg[6]=g
//     an          anodes, active-low, an[0]=ones, an[1]=tens, an[3:2] unused
//     busy        conversion in progress
module product_display
  import product_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] product,
  output logic [6:0]        seg,
  output logic [3:0]        an,
  output logic              busy
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [DATA_W-1:0] last_val;
  logic              start;
  logic              conv_busy;
  logic              conv_done;
  logic [3:0]        conv_tens, conv_ones;
  logic [3:0]        tens, ones;
  logic [CNT_W-1:0]  refresh_cnt;
  logic              sel;

  // Changes arriving mid-conversion are picked up once the converter is
  // idle again, because last_val still holds the previously started value.
  assign start = !conv_busy && (product != last_val);

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (product),
    .busy  (conv_busy),
    .done  (conv_done),
    .tens  (conv_tens),
    .ones  (conv_ones)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_val    <= '0;
      tens        <= '0;
      ones        <= '0;
      refresh_cnt <= '0;
      sel         <= 1'b0;
      seg         <= to_seg_pins(SEG_BLANK);
      an          <= AN_OFF;
    end else begin
      if (start) last_val <= product;
      if (conv_done) begin
        tens <= conv_tens;
        ones <= conv_ones;
      end
      if (refresh_cnt == CNT_LAST) begin
        refresh_cnt <= '0;
        sel         <= ~sel;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      // Output stage: seg and an come from the same select, so they switch together.
      if (sel) begin
        seg <= to_seg_pins(seg_pattern(tens));
        an  <= (tens == 4'd0) ? AN_OFF : AN_TENS;
      end else begin
        seg <= to_seg_pins(seg_pattern(ones));
        an  <= AN_ONES;
      end
    end
  end

  assign busy = conv_busy;

endmodule

// File: tb/tb_product_display.sv
// tb_product_display
//   Bench for product_display with REFRESH_DIV = 4. A cycle-level reference
//   model (decimal value shown, conversion timing, slot timer) predicts
//   seg/an/busy every cycle; directed scenarios and a random phase drive it.
module tb_product_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] product = 6'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;
  logic [6:0] seg_obs;

  int n_checks = 0;
  int n_fail = 0;

  product_display #(.REFRESH_DIV(DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .product (product),
    .seg     (seg),
    .an      (an),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Observed segments in abcdefg order.
  assign seg_obs = {seg[0], seg[1], seg[2], seg[3], seg[4], seg[5], seg[6]};

  logic [6:0] digit_abcdefg [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  // Reference state
  int         m_last = 0;
  int         m_cap = 0;
  int         m_disp = 0;
  int         m_left = 0;
  int         m_cnt = 0;
  int         m_sel = 0;
  logic [6:0] m_seg = 7'h7f;
  logic [3:0] m_an = 4'hf;
  logic       m_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (digit_abcdefg[i] == s) return i;
    return -1;
  endfunction

  // Advance the model by one rising edge using the inputs sampled there.
  task automatic model_edge();
    int d;
    if (!rst_n) begin
      m_last = 0; m_cap = 0; m_disp = 0; m_left = 0;
      m_cnt = 0; m_sel = 0; m_seg = 7'h7f; m_an = 4'hf;
    end else begin
      d     = (m_sel != 0) ? m_disp / 10 : m_disp % 10;
      m_seg = digit_abcdefg[d];
      if (m_sel == 0)            m_an = 4'b1110;
      else if (m_disp / 10 == 0) m_an = 4'b1111;
      else                       m_an = 4'b1101;
      m_cnt++;
      if (m_cnt == DIV) begin
        m_cnt = 0;
        m_sel = 1 - m_sel;
      end
      // Conversion occupies 7 edges after the start edge; display loads on the last.
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_disp = m_cap;
      end else if (int'(product) != m_last) begin
        m_cap  = product;
        m_last = product;
        m_left = 7;
      end
    end
    m_busy = (m_left > 0);
  endtask

  task automatic step(input logic r, input logic [5:0] p);
    @(negedge clk);
    rst_n   = r;
    product = p;
    @(posedge clk);
    model_edge();
    #1;
    chk("seg", 32'(seg_obs), 32'(m_seg));
    chk("an", 32'(an), 32'(m_an));
    chk("busy", 32'(busy), 32'(m_busy));
  endtask

  // Hold p for n cycles, remembering the last pattern seen in each slot.
  task automatic hold_capture(input int n, input logic [5:0] p,
                              output logic [6:0] ones_s, output logic [6:0] tens_s,
                              output logic [3:0] tens_an);
    ones_s  = 7'h7f;
    tens_s  = 7'h7f;
    tens_an = 4'h0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, p);
      if (an == 4'b1110) ones_s = seg_obs;
      else begin
        tens_s  = seg_obs;
        tens_an = an;
      end
    end
  endtask

  task automatic show_check(input string tag, input int v, input logic [5:0] p);
    logic [6:0] os, ts;
    logic [3:0] ta;
    hold_capture(9, p, os, ts, ta);
    hold_capture(2 * DIV, p, os, ts, ta);
    chk({tag, "_ones"}, 32'(decode(os)), 32'(v % 10));
    if (v / 10 == 0) chk({tag, "_tens_blank"}, 32'(ta), 32'hf);
    else begin
      chk({tag, "_tens_an"}, 32'(ta), 32'b1101);
      chk({tag, "_tens"}, 32'(decode(ts)), 32'(v / 10));
    end
  endtask

  initial begin
    int         bcount;
    logic       bseen;
    logic [6:0] os, ts;
    logic [3:0] ta;
    int         run;
    logic       found;
    int         hold;
    logic [5:0] rp;

    // Reset with product 0
    for (int i = 0; i < 3; i++) step(1'b0, 6'd0);
    chk("rst_seg", 32'(seg_obs), 32'h7f);
    chk("rst_an", 32'(an), 32'hf);
    step(1'b1, 6'd0);
    chk("first_an", 32'(an), 32'b1110);
    chk("first_seg", 32'(seg_obs), 32'b0000001);
    bseen = 1'b0;
    for (int i = 0; i < 3 * DIV; i++) begin
      step(1'b1, 6'd0);
      if (busy) bseen = 1'b1;
      if (an != 4'b1110) chk("zero_tens_blank", 32'(an), 32'hf);
    end
    chk("zero_no_busy", 32'(bseen), 32'd0);

    // 0 -> 49
    bcount = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 6'd49);
      if (busy) bcount++;
    end
    chk("busy_len_49", 32'(bcount), 32'd7);
    hold_capture(2 * DIV, 6'd49, os, ts, ta);
    chk("v49_ones_seg", 32'(os), 32'b0000100);
    chk("v49_tens_seg", 32'(ts), 32'b1001100);
    chk("v49_tens_an", 32'(ta), 32'b1101);

    // 63
    hold_capture(9 + 2 * DIV, 6'd63, os, ts, ta);
    chk("v63_ones_seg", 32'(os), 32'b0000110);
    chk("v63_tens_seg", 32'(ts), 32'b0100000);

    // 12, then 35 three cycles later
    for (int i = 0; i < 3; i++) step(1'b1, 6'd12);
    for (int i = 0; i < 6; i++) step(1'b1, 6'd35);
    chk("mid_shows_12", 32'(m_disp), 32'd12);
    show_check("v35", 35, 6'd35);

    // Reset in the middle of a 0 -> 42 conversion
    step(1'b0, 6'd0);
    step(1'b1, 6'd0);
    step(1'b1, 6'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 6'd42);
    step(1'b0, 6'd42);
    chk("abort_seg", 32'(seg_obs), 32'h7f);
    chk("abort_an", 32'(an), 32'hf);
    chk("abort_busy", 32'(busy), 32'd0);
    step(1'b1, 6'd42);
    chk("abort_shows0_an", 32'(an), 32'b1110);
    chk("abort_shows0_seg", 32'(seg_obs), 32'b0000001);
    show_check("v42", 42, 6'd42);

    // Slot period
    found = 1'b0;
    for (int i = 0; i < 3 * DIV && !found; i++) begin
      step(1'b1, 6'd42);
      if (an == 4'b1101) found = 1'b1;
    end
    chk("slot_sync_tens", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 3 * DIV && !found; i++) begin
      step(1'b1, 6'd42);
      if (an == 4'b1110) found = 1'b1;
    end
    chk("slot_sync_ones", 32'(found), 32'd1);
    run = 1;
    for (int i = 0; i < 3 * DIV; i++) begin
      step(1'b1, 6'd42);
      if (an != 4'b1110) break;
      run++;
    end
    chk("slot_len", 32'(run), 32'(DIV));

    // Sweep a*b for a,b in 0..3 plus 7*7
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        show_check("sweep", a * b, 6'(a * b));
    show_check("sweep", 49, 6'd49);

    // Random changes with occasional reset pulses
    for (int k = 0; k < 60; k++) begin
      hold = $urandom_range(1, 12);
      rp   = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 19) == 0) step(1'b0, rp);
      for (int i = 0; i < hold; i++) step(1'b1, rp);
    end
    for (int i = 0; i < 12; i++) step(1'b1, rp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
